// File: rtl/common.sv
// Basic shared types used across the core's memory-side blocks.
package common;
    typedef logic [63:0] u64;
    typedef logic [7:0]  u8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;
endpackage

// File: rtl/dbus_responder_pkg.sv
// Data-bus responder types and helpers: FSM states, strobe expansion, size decode.
package dbus_responder_pkg;
    import common::*;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dbus_state_t;

    function automatic u64 strobe_to_mask(input u8 strobe);
        u64 mask;
        mask = '0;
        for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{strobe[b]}};
        return mask;
    endfunction

    // Undefined encodings are treated as a full doubleword.
    function automatic logic [3:0] msize_bytes(input msize_t size);
        case (size)
            MSIZE1:  return 4'd1;
            MSIZE2:  return 4'd2;
            MSIZE4:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction
endpackage

// File: rtl/dbus_ram.sv
// Word-addressed 64-bit RAM: byte-masked synchronous write, combinational read, no reset.
module dbus_ram
    import common::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wmask,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);
    u64 mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/dbus_responder.sv
// Single-outstanding data-bus target: accepts a request, waits LATENCY cycles,
// then completes it against the internal RAM (read, byte-merged write, or error).
module dbus_responder
    import common::*;
    import dbus_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data,
    output logic        resp_err
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    dbus_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        first, first_nxt;
    logic        load;

    u64     h_addr, h_data;
    msize_t h_size;
    u8      h_strobe;

    u64          off, rdata, wmask;
    logic        in_range, misaligned, err, is_write, done, we;
    logic [2:0]  align_mask;
    logic [AW-1:0] idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            first <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            first <= first_nxt;
        end
    end

    // Holding registers are only meaningful in BUSY, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            h_addr   <= req_addr;
            h_size   <= msize_t'(req_size);
            h_strobe <= req_strobe;
            h_data   <= req_data;
        end
    end

    assign done = (state == BUSY) && (cnt == 4'd1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        first_nxt = first;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'(LATENCY);
                    first_nxt = 1'b1;
                    load      = 1'b1;
                end
            end
            BUSY: begin
                first_nxt = 1'b0;
                cnt_nxt   = cnt - 4'd1;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign off        = h_addr - BASE_ADDR;
    assign in_range   = (h_addr >= BASE_ADDR) && ((off >> 3) < u64'(MEM_WORDS));
    assign align_mask = 3'(msize_bytes(h_size) - 4'd1);
    assign misaligned = (h_addr[2:0] & align_mask) != 3'd0;
    assign err        = !in_range || misaligned;
    assign is_write   = h_strobe != 8'd0;
    assign idx        = off[AW+2:3];
    assign wmask      = strobe_to_mask(h_strobe);
    assign we         = done && is_write && !err;

    dbus_ram #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (idx),
        .wmask (wmask),
        .wdata (h_data),
        .rdata (rdata)
    );

    // Outputs decode registered state only; nothing flows from req_* to resp_*.
    assign resp_addr_ok = (state == BUSY) && first;
    assign resp_data_ok = done;
    assign resp_err     = done && err;
    assign resp_data    = (done && !err && !is_write) ? rdata : 64'd0;
endmodule
